uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Parametrised UART transmitter, successor to the fixed 8N1 transmitter.
- Configurable data width, parity mode, stop-bit count and baud divisor.
- Ready/valid input with an internal FIFO, so a producer can queue several characters.
- Frames stream back-to-back with no idle gap; sits between the system bus/packetiser and the tx pin.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 115_200, line rate. CPB = CLK_FREQ/BAUD_RATE clock cycles per bit, must be >= 1 (elaboration error otherwise).
- DATA_BITS, 8, payload bits per frame, legal range 5..9.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, number of stop bits, 1 or 2.
- FIFO_DEPTH, 4, entries in input FIFO, power of two, >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  producer has a character on in_data.
- in_data  input  DATA_BITS  character to send, LSB transmitted first.
- in_ready  output  1  FIFO can accept; high iff FIFO not full.
- tx  output  1  serial line, registered, idle high.
- busy  output  1  high while FSM is not IDLE.
- tx_done  output  1  one-cycle pulse at end of each frame's last stop bit.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset, asynchronous, any state: FSM=IDLE, tx=1, busy=0, tx_done=0, FIFO empty (fifo_count=0, in_ready=1), baud counter and bit index cleared. An in-flight frame is abandoned and queued data is discarded.
- Push: on a rising edge with in_valid && in_ready, in_data is written to the FIFO tail. in_data is sampled only on that edge.
- Pop: the head is popped into the shift register on the edge where the FSM enters START.
- Simultaneous push and pop: allowed when not full; occupancy unchanged.
- When full, in_ready=0 and pushes are ignored, even if a pop occurs that cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If FIFO non-empty, go to START on the next edge and pop; tx=0 from that edge.
  - START: tx=0 for CPB cycles, then DATA.
  - DATA: tx = shift_reg[0] for CPB cycles per bit, shift right; DATA_BITS bits, index 0..DATA_BITS-1.
  - After DATA: go to PARITY if PARITY != 0, else STOP.
  - PARITY: tx = ^data for even mode, ~^data for odd mode, held CPB cycles.
  - STOP: tx=1 for STOP_BITS*CPB cycles.
- End of STOP: tx_done pulses for that single cycle. Then go to START (popping) if FIFO non-empty, else IDLE. No idle bit between queued frames.
- Baud counter: counts 0..CPB-1 and resets on every state or bit transition; every bit is exactly CPB cycles.
- Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CPB cycles.
- Latency: the first start bit appears on tx one cycle after the push edge into an empty, idle block.
- DATA_BITS=9: in_data is 9 bits wide, and parity covers all 9 bits.

Test Plan:
- CPB=2, 8N1: push 0x55 into an idle block -> tx sequence 0,1,0,1,0,1,0,1,0,1, each value held 2 cycles; one tx_done pulse; busy high for exactly 20 cycles; then IDLE with tx=1.
- PARITY=2 (even), then PARITY=1 (odd), data 0x07 -> parity bit 1 for even, 0 for odd, placed after bit 7 and before the stop bit.
- STOP_BITS=2, DATA_BITS=5, push 0x1A -> start, bits 0,1,0,1,1, then tx=1 for 4 cycles; frame is 16 cycles at CPB=2.
- FIFO_DEPTH=4: hold in_valid high with data 0x01..0x06 -> in_ready drops when fifo_count=4; no character is lost; frames are emitted in order 0x01..0x06 with no idle gap; 6 tx_done pulses.
- Reset mid-frame: assert rst during DATA with 2 entries queued -> next edge shows tx=1, busy=0, fifo_count=0, in_ready=1. A later push of 0xA5 transmits correctly from a clean start bit.
- Push while full and popping in the same cycle -> push ignored; fifo_count goes 4->3.

Source files
------------

// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : Parametrised UART transmitter with an input FIFO. Characters
//             accepted on a ready/valid interface are queued and sent as
//             start / DATA_BITS data (LSB first) / optional parity / stop
//             frames. Queued frames follow each other with no idle bit.
//  Ports    : clk        - system clock, rising edge
//             rst        - asynchronous active-high reset
//             in_valid   - producer offers in_data
//             in_data    - character to queue (DATA_BITS wide)
//             in_ready   - high while the FIFO is not full
//             tx         - registered serial output, idle high
//             busy       - high whenever a frame is in progress
//             tx_done    - one-cycle pulse in the last cycle of a frame
//             fifo_count - current FIFO occupancy
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [DATA_BITS-1:0]          in_data,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int c_cpb   = CLK_FREQ / BAUD_RATE;
  // A one-cycle bit still needs a 1-bit counter so the compare below is legal.
  localparam int c_cnt_w = (c_cpb > 1) ? $clog2(c_cpb) : 1;
  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_cw    = c_ptr_w + 1;

  localparam logic [c_cnt_w-1:0] c_baud_last = c_cnt_w'(c_cpb - 1);
  localparam logic [3:0]         c_data_last = 4'(DATA_BITS - 1);
  localparam logic [3:0]         c_stop_last = 4'(STOP_BITS - 1);
  localparam logic [c_cw-1:0]    c_full      = c_cw'(FIFO_DEPTH);

  localparam logic [2:0] c_idle   = 3'd0;
  localparam logic [2:0] c_start  = 3'd1;
  localparam logic [2:0] c_data   = 3'd2;
  localparam logic [2:0] c_parity = 3'd3;
  localparam logic [2:0] c_stop   = 3'd4;

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  generate
    if (c_cpb < 1) begin : g_chk_cpb
      $error("uart_tx_fifo: CLK_FREQ/BAUD_RATE must be at least 1");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data_bits
      $error("uart_tx_fifo: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_chk_parity
      $error("uart_tx_fifo: PARITY must be 0 (none), 1 (odd) or 2 (even)");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop_bits
      $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Input FIFO
  // --------------------------------------------------------------------------
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_cw-1:0]      r_count;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic [DATA_BITS-1:0] w_head;
  logic                 w_head_par;

  assign w_full  = (r_count == c_full);
  assign w_empty = (r_count == '0);
  // Fullness is judged on the registered count only, so a push offered in the
  // same cycle as a pop from a full FIFO is still refused.
  assign w_push  = in_valid && !w_full;
  assign w_head  = r_mem[r_rd_ptr];

  // Parity is computed once at pop time from the whole character, so it does
  // not depend on the shift register contents later in the frame.
  assign w_head_par = (PARITY == 2) ? (^w_head) : (~^w_head);

  // Storage needs no reset: entries are only read when counted as valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Transmit state machine
  // --------------------------------------------------------------------------
  logic [2:0]           r_state;
  logic [c_cnt_w-1:0]   r_baud;
  logic [3:0]           r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;
  logic                 r_tx;

  logic                 w_bit_end;
  logic                 w_last_stop;

  assign w_bit_end   = (r_baud == c_baud_last);
  // Final cycle of the final stop bit: the frame ends on the coming edge.
  assign w_last_stop = (r_state == c_stop) && (r_bit == c_stop_last) && w_bit_end;
  // A new frame starts either from idle or directly out of the last stop
  // cycle, which is what makes queued frames back-to-back.
  assign w_pop       = !w_empty && ((r_state == c_idle) || w_last_stop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= c_idle;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_tx     <= 1'b1;
    end else if (w_pop) begin
      r_state  <= c_start;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= w_head;
      r_parity <= w_head_par;
      r_tx     <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          r_tx <= 1'b1;
        end

        c_start: begin
          if (w_bit_end) begin
            r_state <= c_data;
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        c_data: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit == c_data_last) begin
              r_bit <= '0;
              if (PARITY != 0) begin
                r_state <= c_parity;
                r_tx    <= r_parity;
              end else begin
                r_state <= c_stop;
                r_tx    <= 1'b1;
              end
            end else begin
              // tx is registered, so it takes the bit that becomes LSB next.
              r_bit   <= r_bit + 1'b1;
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        c_parity: begin
          if (w_bit_end) begin
            r_state <= c_stop;
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b1;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        c_stop: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit == c_stop_last) begin
              // FIFO empty here, otherwise the pop branch above was taken.
              r_state <= c_idle;
              r_bit   <= '0;
              r_tx    <= 1'b1;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        default: begin
          r_state <= c_idle;
          r_baud  <= '0;
          r_bit   <= '0;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign tx         = r_tx;
  assign busy       = (r_state != c_idle);
  assign tx_done    = w_last_stop;
  assign in_ready   = !w_full;
  assign fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Purpose  : Self-checking bench for uart_tx_fifo. Four instances at
//             CPB=2: 8N1, 8E1, 8O1 and 5N2, all with a 4-entry FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int NI    = 4;
  localparam int CPB   = 2;
  localparam int DEPTH = 4;

  function automatic int db_of(input int g);
    return (g == 3) ? 5 : 8;
  endfunction
  function automatic int par_of(input int g);
    return (g == 1) ? 2 : ((g == 2) ? 1 : 0);
  endfunction
  function automatic int stop_of(input int g);
    return (g == 3) ? 2 : 1;
  endfunction

  logic       clk = 1'b0;
  logic       rst;
  logic       vin   [NI];
  logic [8:0] din   [NI];
  logic       rdy   [NI];
  logic       txo   [NI];
  logic       busyo [NI];
  logic       doneo [NI];
  logic [2:0] cnto  [NI];

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      uart_tx_fifo #(
        .CLK_FREQ   (CPB),
        .BAUD_RATE  (1),
        .DATA_BITS  (db_of(g)),
        .PARITY     (par_of(g)),
        .STOP_BITS  (stop_of(g)),
        .FIFO_DEPTH (DEPTH)
      ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (vin[g]),
        .in_data    (din[g][db_of(g)-1:0]),
        .in_ready   (rdy[g]),
        .tx         (txo[g]),
        .busy       (busyo[g]),
        .tx_done    (doneo[g]),
        .fifo_count (cnto[g])
      );
    end
  endgenerate

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  // --------------------------------------------------------------------------
  // Reference model: a character queue plus the current frame as a bit list
  // and a cycle position inside it.
  // --------------------------------------------------------------------------
  logic [8:0]  pq   [NI][64];
  int          ph   [NI];
  int          pt   [NI];
  bit          act  [NI];
  int          tpos [NI];
  int          flen [NI];
  logic [15:0] fb   [NI];

  function automatic void build(input int g, input logic [8:0] d,
                                output logic [15:0] bits, output int len);
    int nb;
    logic p;
    bits    = '1;
    bits[0] = 1'b0;
    p       = 1'b0;
    for (int i = 0; i < db_of(g); i++) begin
      bits[1+i] = d[i];
      p         = p ^ d[i];
    end
    nb = 1 + db_of(g);
    if (par_of(g) != 0) begin
      bits[nb] = (par_of(g) == 2) ? p : ~p;
      nb++;
    end
    nb  = nb + stop_of(g);
    len = nb * CPB;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int g = 0; g < NI; g++) begin
        ph[g] = 0; pt[g] = 0; act[g] = 1'b0; tpos[g] = 0;
      end
    end else begin
      for (int g = 0; g < NI; g++) begin
        int occ;
        bit ending;
        bit psh;
        occ    = pt[g] - ph[g];
        ending = act[g] && (tpos[g] == flen[g] - 1);
        psh    = vin[g] && (occ < DEPTH);
        if ((!act[g] || ending) && occ > 0) begin
          build(g, pq[g][ph[g] % 64], fb[g], flen[g]);
          ph[g]++;
          act[g]  = 1'b1;
          tpos[g] = 0;
        end else if (ending) begin
          act[g] = 1'b0;
        end else if (act[g]) begin
          tpos[g]++;
        end
        if (psh) begin
          pq[g][pt[g] % 64] = din[g];
          pt[g]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int g = 0; g < NI; g++) begin
        logic et, eb, ed, er;
        int   ec;
        et = act[g] ? fb[g][tpos[g] / CPB] : 1'b1;
        eb = act[g];
        ed = act[g] && (tpos[g] == flen[g] - 1);
        ec = pt[g] - ph[g];
        er = (ec < DEPTH);
        nvec++;
        if (txo[g] !== et || busyo[g] !== eb || doneo[g] !== ed ||
            int'(cnto[g]) != ec || rdy[g] !== er) begin
          nerr++;
          if (nerr < 40)
            $display("FAIL model[%0d] @%0t: tx/busy/done/cnt/rdy got %b/%b/%b/%0d/%b expected %b/%b/%b/%0d/%b",
                     g, $time, txo[g], busyo[g], doneo[g], cnto[g], rdy[g], et, eb, ed, ec, er);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed checks
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  typedef struct {
    logic       v;
    logic [8:0] d;
    logic       tx;
    logic       busy;
    logic       done;
    int         cnt;
    logic       rdy;
  } vec_t;

  vec_t        tbl [22];
  logic [9:0]  seq55 = 10'b1010101010;   // 0x55 8N1 frame, index 0 first
  logic [7:0]  seq1a = 8'b11110100;      // 0x1A 5N2 frame, one entry per bit
  logic [9:0]  seqa5 = 10'b1101001010;   // 0xA5 8N1 frame
  int          d, ndone, thr;
  bit          r, fp, seen;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 9'h055, 1'b1, 1'b0, 1'b0, 1, 1'b1};
    for (int i = 1; i <= 20; i++)
      tbl[i] = '{1'b0, 9'h000, seq55[(i-1)/2], 1'b1, (i == 20), 0, 1'b1};
    tbl[21] = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 0, 1'b1};

    rst = 1'b1;
    for (int g = 0; g < NI; g++) begin vin[g] = 1'b0; din[g] = '0; end
    repeat (3) step();
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("reset[%0d].tx", g), txo[g], 1);
      chk($sformatf("reset[%0d].busy", g), busyo[g], 0);
      chk($sformatf("reset[%0d].tx_done", g), doneo[g], 0);
      chk($sformatf("reset[%0d].fifo_count", g), cnto[g], 0);
      chk($sformatf("reset[%0d].in_ready", g), rdy[g], 1);
    end
    rst = 1'b0;
    chk_en = 1'b1;
    step(); step();

    // 8N1, 0x55 into an idle block, cycle by cycle
    for (int i = 0; i < 22; i++) begin
      vin[0] = tbl[i].v;
      din[0] = tbl[i].d;
      step();
      chk($sformatf("tbl[%0d].tx", i), txo[0], tbl[i].tx);
      chk($sformatf("tbl[%0d].busy", i), busyo[0], tbl[i].busy);
      chk($sformatf("tbl[%0d].tx_done", i), doneo[0], tbl[i].done);
      chk($sformatf("tbl[%0d].fifo_count", i), cnto[0], tbl[i].cnt);
      chk($sformatf("tbl[%0d].in_ready", i), rdy[0], tbl[i].rdy);
    end

    // 0x07 with even (inst 1) and odd (inst 2) parity
    vin[1] = 1'b1; vin[2] = 1'b1; din[1] = 9'h007; din[2] = 9'h007;
    step();
    vin[1] = 1'b0; vin[2] = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      step();
      if (k == 18) begin
        chk("even.bit7", txo[1], 0);
        chk("odd.bit7", txo[2], 0);
      end
      if (k == 19 || k == 20) begin
        chk($sformatf("even.parity.k%0d", k), txo[1], 1);
        chk($sformatf("odd.parity.k%0d", k), txo[2], 0);
      end
      if (k == 21) begin
        chk("even.stop", txo[1], 1);
        chk("odd.stop", txo[2], 1);
      end
    end
    repeat (4) step();

    // 5 data bits, 2 stop bits, 0x1A: 16-cycle frame
    vin[3] = 1'b1; din[3] = 9'h01A;
    step();
    vin[3] = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k <= 16) begin
        chk($sformatf("5n2.tx.k%0d", k), txo[3], seq1a[(k-1)/2]);
        chk($sformatf("5n2.busy.k%0d", k), busyo[3], 1);
        chk($sformatf("5n2.done.k%0d", k), doneo[3], (k == 16));
      end else begin
        chk("5n2.idle.tx", txo[3], 1);
        chk("5n2.idle.busy", busyo[3], 0);
      end
    end

    // FIFO fill: in_valid held with 0x01..0x06
    d = 1; vin[0] = 1'b1; din[0] = 9'(d); ndone = 0; seen = 1'b0;
    for (int c = 0; c < 600 && !(d == 7 && !busyo[0] && cnto[0] == 0); c++) begin
      r  = rdy[0];
      fp = (cnto[0] == 3'd4) && doneo[0];
      step();
      if (doneo[0]) ndone++;
      if (fp && vin[0]) begin
        seen = 1'b1;
        chk("full_pop.fifo_count", cnto[0], 3);
      end
      if (cnto[0] == 3'd4) chk("full.in_ready", rdy[0], 0);
      if (vin[0] && r) begin
        d++;
        if (d == 7) vin[0] = 1'b0;
        else        din[0] = 9'(d);
      end
    end
    chk("fifo.accepted", d, 7);
    chk("fifo.drained_busy", busyo[0], 0);
    chk("fifo.tx_done_pulses", ndone, 6);
    chk("fifo.full_pop_seen", seen, 1);

    // Reset during DATA with two entries queued
    vin[0] = 1'b1; din[0] = 9'h011; step();
    din[0] = 9'h022; step();
    din[0] = 9'h033; step();
    vin[0] = 1'b0;
    repeat (4) step();
    chk("rst.pre.queued", cnto[0], 2);
    chk("rst.pre.busy", busyo[0], 1);
    rst = 1'b1;
    #1;
    chk("rst.async.tx", txo[0], 1);
    chk("rst.async.busy", busyo[0], 0);
    chk("rst.async.fifo_count", cnto[0], 0);
    chk("rst.async.in_ready", rdy[0], 1);
    step();
    chk("rst.edge.tx", txo[0], 1);
    chk("rst.edge.busy", busyo[0], 0);
    chk("rst.edge.tx_done", doneo[0], 0);
    rst = 1'b0;
    step();
    vin[0] = 1'b1; din[0] = 9'h0A5;
    step();
    vin[0] = 1'b0;
    chk("a5.pushed", cnto[0], 1);
    chk("a5.still_idle", txo[0], 1);
    for (int k = 1; k <= 21; k++) begin
      step();
      if (k <= 20) chk($sformatf("a5.tx.k%0d", k), txo[0], seqa5[(k-1)/2]);
      else         chk("a5.idle", busyo[0], 0);
    end

    // Randomized traffic on all instances, model-checked every cycle
    for (int p = 0; p < 3; p++) begin
      thr = (p == 0) ? 15 : ((p == 1) ? 50 : 97);
      repeat (1500) begin
        for (int g = 0; g < NI; g++) begin
          vin[g] = ($urandom_range(0, 99) < thr);
          din[g] = 9'($urandom);
        end
        step();
      end
    end
    for (int g = 0; g < NI; g++) vin[g] = 1'b0;
    repeat (200) step();
    for (int g = 0; g < NI; g++)
      chk($sformatf("drain[%0d].busy", g), busyo[g], 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
